// File: rtl/pipe_pkg.sv
// pipe_pkg: constants shared between the hazard controller, its md busy counter and the
// pipeline stages that consume the forwarding selects.
//   FWD_*        forwarding select encoding for the D-stage operand muxes
//   TUSE_NONE    T_use value meaning "operand not read"
//   *_DEFAULT    default multiply/divide unit occupancy in cycles
package pipe_pkg;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;

   localparam logic [2:0] TUSE_NONE = 3'd7;

   localparam int unsigned MULT_CYCLES_DEFAULT = 5;
   localparam int unsigned DIV_CYCLES_DEFAULT  = 10;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: bundles the D/E/M/W hazard inputs and the stall/forward outputs.
//   master  : pipeline side (drives stage info, receives stall/enable/forward controls)
//   slave   : hazard controller side
// Optional: HAZARD_STALL_CNT_EN adds the stall_cnt statistics output.
interface hazard_stall_ctrl_if;

   logic       D_valid;
   logic [4:0] D_rs;
   logic [4:0] D_rt;
   logic [2:0] D_tuse_rs;
   logic [2:0] D_tuse_rt;
   logic       D_md_op;
   logic [4:0] E_A3;
   logic [4:0] E_tnew;
   logic [4:0] M_A3;
   logic [4:0] M_tnew;
   logic [4:0] W_A3;
   logic       E_md_start;
   logic       E_md_is_div;

   logic       stall;
   logic       en_PC;
   logic       en_FD;
   logic       clr_DE;
   logic [1:0] fwd_rs;
   logic [1:0] fwd_rt;
   logic       md_busy;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   modport master (
      output D_valid, D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md_op,
      output E_A3, E_tnew, M_A3, M_tnew, W_A3, E_md_start, E_md_is_div,
`ifdef HAZARD_STALL_CNT_EN
      input  stall_cnt,
`endif
      input  stall, en_PC, en_FD, clr_DE, fwd_rs, fwd_rt, md_busy
   );

   modport slave (
      input  D_valid, D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md_op,
      input  E_A3, E_tnew, M_A3, M_tnew, W_A3, E_md_start, E_md_is_div,
`ifdef HAZARD_STALL_CNT_EN
      output stall_cnt,
`endif
      output stall, en_PC, en_FD, clr_DE, fwd_rs, fwd_rt, md_busy
   );

endinterface

// File: rtl/md_busy_counter.sv
// md_busy_counter: occupancy counter for the multiply/divide unit.
//   clk, reset  clock and asynchronous active-high reset
//   start       mult/div issued from E this cycle
//   is_div      qualifies start: 1 = div/divu, 0 = mult/multu
//   md_busy     unit occupied (counter non-zero)
// A start loads the full latency, so md_busy is high for exactly MULT_CYCLES or DIV_CYCLES
// cycles after the issuing edge. A start while busy is ignored.
module md_busy_counter #(
   parameter int unsigned MULT_CYCLES = pipe_pkg::MULT_CYCLES_DEFAULT,
   parameter int unsigned DIV_CYCLES  = pipe_pkg::DIV_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic md_busy
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start && (cnt_q == 4'd0)) begin
         cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central hazard unit for the F/D/E/M/W pipeline.
//   clk, reset  clock and asynchronous active-high reset
//   bus         hazard_stall_ctrl_if.slave: D-stage operand use times, E/M/W producer
//               destinations and ready times, md start; returns stall, PC/FD enables,
//               D/E bubble, D-stage forwarding selects and md_busy.
// Optional: define HAZARD_STALL_CNT_EN to add a saturating 32-bit stall cycle counter.
module hazard_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   hazard_stall_ctrl_if.slave bus
);

   logic haz_rs, haz_rt, md_stall, stall, md_busy;

   // A producer stalls D only if its result arrives after the consumer needs it.
   // W results are always ready and never stall.
   assign haz_rs = bus.D_valid && (bus.D_rs != 5'd0) && (bus.D_tuse_rs != TUSE_NONE) &&
                   (((bus.E_A3 == bus.D_rs) && (bus.E_tnew > {2'b00, bus.D_tuse_rs})) ||
                    ((bus.M_A3 == bus.D_rs) && (bus.M_tnew > {2'b00, bus.D_tuse_rs})));

   assign haz_rt = bus.D_valid && (bus.D_rt != 5'd0) && (bus.D_tuse_rt != TUSE_NONE) &&
                   (((bus.E_A3 == bus.D_rt) && (bus.E_tnew > {2'b00, bus.D_tuse_rt})) ||
                    ((bus.M_A3 == bus.D_rt) && (bus.M_tnew > {2'b00, bus.D_tuse_rt})));

   // The start cycle itself also stalls: the counter only reads busy from the next edge.
   assign md_stall = bus.D_valid && bus.D_md_op && (md_busy || bus.E_md_start);

   assign stall = haz_rs || haz_rt || md_stall;

   // Newest matching producer wins; if it is not ready yet the select falls back to RF,
   // which is harmless because the stall logic holds D in that case.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] e_a3, input logic [4:0] e_tnew,
                                          input logic [4:0] m_a3, input logic [4:0] m_tnew,
                                          input logic [4:0] w_a3);
      logic [1:0] sel;
      sel = FWD_RF;
      if (src == 5'd0) begin
         sel = FWD_RF;
      end else if (e_a3 == src) begin
         sel = (e_tnew == 5'd0) ? FWD_E : FWD_RF;
      end else if (m_a3 == src) begin
         sel = (m_tnew == 5'd0) ? FWD_M : FWD_RF;
      end else if (w_a3 == src) begin
         sel = FWD_W;
      end
      return sel;
   endfunction

   assign bus.fwd_rs = fwd_sel(bus.D_rs, bus.E_A3, bus.E_tnew, bus.M_A3, bus.M_tnew, bus.W_A3);
   assign bus.fwd_rt = fwd_sel(bus.D_rt, bus.E_A3, bus.E_tnew, bus.M_A3, bus.M_tnew, bus.W_A3);

   assign bus.stall   = stall;
   assign bus.en_PC   = ~stall;
   assign bus.en_FD   = ~stall;
   assign bus.clr_DE  = stall;
   assign bus.md_busy = md_busy;

   md_busy_counter #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_counter (
      .clk     (clk),
      .reset   (reset),
      .start   (bus.E_md_start),
      .is_div  (bus.E_md_is_div),
      .md_busy (md_busy)
   );

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= 32'd0;
      end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline (F/D/E/M/W).
- Compares D-stage source-register use times (T_use) against in-flight producer write times (T_new) in E, M and W, and generates stall/bubble controls for the PC and pipeline registers.
- Produces D-stage forwarding selects.
- Owns the multiply/divide unit's busy counter, so the D stage stalls on mult/div-family instructions while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start (1..15).
- DIV_CYCLES, 10, busy cycles after a div/divu start (1..15).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- D_valid  in  1  D stage holds a real instruction.
- D_rs  in  5  rs index of D instruction.
- D_rt  in  5  rt index of D instruction.
- D_tuse_rs  in  3  cycles until rs is consumed; 7 = unused.
- D_tuse_rt  in  3  cycles until rt is consumed; 7 = unused.
- D_md_op  in  1  D instruction uses the md unit (mult/div/mfhi/mflo/mthi/mtlo).
- E_A3  in  5  destination register of E instruction; 0 = none.
- E_tnew  in  5  remaining cycles until E result is ready.
- M_A3  in  5  destination register of M instruction.
- M_tnew  in  5  remaining cycles until M result is ready.
- W_A3  in  5  destination register of W instruction.
- E_md_start  in  1  E-stage mult/div issues this cycle.
- E_md_is_div  in  1  qualifies E_md_start: 1 = div, 0 = mult.
- stall  out  1  hazard detected this cycle.
- en_PC  out  1  PC write enable (= ~stall).
- en_FD  out  1  F/D register enable (= ~stall).
- clr_DE  out  1  D/E register synchronous clear (bubble) (= stall).
- fwd_rs  out  2  D rs source: 0 RF, 1 E, 2 M, 3 W.
- fwd_rt  out  2  D rt source: same encoding as fwd_rs.
- md_busy  out  1  md unit occupied (registered state).

Behaviour:
- reset asserted (async): md counter = 0, so md_busy = 0. Combinational outputs follow inputs.
- At reset with all-zero inputs: stall = 0, en_PC = en_FD = 1, clr_DE = 0, fwd_* = 0.

Register-hazard stall (combinational, same cycle):
- For src in {rs, rt}: hazard if D_valid, src != 0, tuse != 7, and either
  - E_A3 == src && E_tnew > tuse, or
  - M_A3 == src && M_tnew > tuse.
- W never stalls; W values are always ready.

MD stall:
- D_valid && D_md_op && (md_busy || E_md_start).

stall = OR of all hazard terms.

Forwarding:
- For src != 0: priority E (E_A3 == src && E_tnew == 0) > M (M_tnew == 0) > W > RF.
- src == 0 always selects 0.
- A newer producer with tnew > 0 masks older ones; select 0 in that case, since the stall covers it.

MD busy counter:
- 4-bit counter, reset 0.
- E_md_start with counter 0: load DIV_CYCLES or MULT_CYCLES next edge.
- Else if counter != 0: decrement by 1.
- md_busy = (counter != 0).
- Full latency: start at edge N means md_busy is high for exactly MULT_CYCLES/DIV_CYCLES cycles starting after edge N.
- E_md_start while md_busy: ignored, counter continues decrementing. This case is architecturally impossible; the bench flags it with an assertion.
- Reset mid-count: counter clears immediately, md_busy drops asynchronously.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0].
  - Increments on every clk edge with stall = 1.
  - Saturates at 32'hFFFF_FFFF.
  - Clears on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_RF = 0, FWD_E = 1, FWD_M = 2, FWD_W = 3.
  - TUSE_NONE = 3'd7.
  - MULT_CYCLES and DIV_CYCLES defaults.
- One natural sub-module, md_busy_counter: load/decrement counter plus md_busy output. The hazard compare and forward logic stay inline.

Test Plan:
- Load-use: E_A3 = 5, E_tnew = 2, D_rs = 5, D_tuse_rs = 0 → stall = 1, en_PC = 0, clr_DE = 1. Next cycle M_A3 = 5, M_tnew = 1 → still stalled. Then W_A3 = 5 → stall = 0, fwd_rs = 3.
- ALU forward: M_A3 = 8, M_tnew = 0, D_rt = 8, D_tuse_rt = 1 → stall = 0, fwd_rt = 2. With D_rt = 0 and M_A3 = 0 → fwd_rt = 0.
- Priority: E_A3 = M_A3 = W_A3 = 3, E_tnew = 0, M_tnew = 0 → fwd_rs = 1. Set E_tnew = 1 with D_tuse_rs = 0 → stall = 1.
- Mult busy: E_md_start = 1, E_md_is_div = 0 at edge 0 → md_busy high for edges 1..5 inclusive, low after. D_md_op = 1 stalls throughout, including the start cycle.
- Async reset: during a div with counter = 6, pulse reset between edges → md_busy = 0 immediately, stall from md = 0.
- HAZARD_STALL_CNT_EN: 7 stall cycles after reset → stall_cnt = 7. Preload near max → saturates at FFFF_FFFF.
